// File: rtl/vbuff_pkg.sv
// Shared definitions for the video buffer writer and reader: writer state
// encoding and default frame geometry.
package vbuff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WRITE = 2'd2,
    FULL  = 2'd3
  } wr_state_e;

  localparam int VB_WIDTH  = 640;
  localparam int VB_HEIGHT = 480;

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: col/row plus a linear address kept as its own
// counter so no multiplier is needed. Clear and increment may coincide.
module raster_counter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [15:0]       col_o,
  output logic [15:0]       row_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [15:0]       col_q, col_d, col_b;
  logic [15:0]       row_q, row_d, row_b;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_b;

  always_comb begin
    // clr selects position 0 as the base, so clr+inc lands on index 1
    col_b  = clr ? '0 : col_q;
    row_b  = clr ? '0 : row_q;
    addr_b = clr ? '0 : addr_q;
    col_d  = col_b;
    row_d  = row_b;
    addr_d = addr_b;
    if (inc) begin
      if (col_b == 16'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_b == 16'(HEIGHT - 1)) ? '0 : row_b + 16'd1;
      end else begin
        col_d = col_b + 16'd1;
      end
      addr_d = (addr_b == ADDR_W'(WIDTH * HEIGHT - 1)) ? '0 : addr_b + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = addr_q;
  assign last_o = (col_q == 16'(WIDTH - 1)) && (row_q == 16'(HEIGHT - 1));

endmodule

// File: rtl/vbuff_writer.sv
// Captures one camera frame at a time into the video buffer in raster order,
// aligned to sof_i, flagging short and long frames.
module vbuff_writer
  import vbuff_pkg::*;
#(
  parameter int WIDTH  = VB_WIDTH,
  parameter int HEIGHT = VB_HEIGHT,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              capture_en_i,
  input  logic              sof_i,
  input  logic              valid_i,
  input  logic [3:0]        pixel_i,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic              w_en_o,
  output logic [3:0]        w_data_o,
  output logic [15:0]       row_o,
  output logic [15:0]       col_o,
  output logic              frame_done_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int TOTAL = WIDTH * HEIGHT;

  wr_state_e         st_q, st_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [3:0]        w_data_q, w_data_d;
  logic [15:0]       row_q, row_d, col_q, col_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              sticky_q, sticky_d;

  logic              cnt_clr, cnt_inc, cnt_last, start_frame;
  logic [15:0]       cnt_col, cnt_row;
  logic [ADDR_W-1:0] cnt_addr;

  raster_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_cnt (
    .clk   (pclk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .col_o (cnt_col),
    .row_o (cnt_row),
    .addr_o(cnt_addr),
    .last_o(cnt_last)
  );

  always_comb begin
    st_d        = st_q;
    w_en_d      = 1'b0;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    row_d       = row_q;
    col_d       = col_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    sticky_d    = sticky_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    start_frame = 1'b0;

    case (st_q)
      IDLE: begin
        if (capture_en_i) st_d = ARMED;
      end
      ARMED: begin
        if (sof_i) begin
          st_d        = WRITE;
          start_frame = 1'b1;
        end
      end
      WRITE: begin
        if (sof_i) begin
          err_d = 1'b1;
          if (capture_en_i) begin
            start_frame = 1'b1;
          end else begin
            st_d    = IDLE;
            cnt_clr = 1'b1;
          end
        end else if (valid_i) begin
          w_en_d   = 1'b1;
          w_data_d = pixel_i;
          w_addr_d = cnt_addr;
          row_d    = cnt_row;
          col_d    = cnt_col;
          cnt_inc  = 1'b1;
          if (cnt_last) begin
            st_d     = FULL;
            done_d   = 1'b1;
            sticky_d = 1'b0;
          end
        end
      end
      FULL: begin
        if (sof_i) begin
          sticky_d = 1'b0;
          if (capture_en_i) begin
            st_d        = WRITE;
            start_frame = 1'b1;
          end else begin
            st_d    = IDLE;
            cnt_clr = 1'b1;
          end
        end else if (valid_i && !sticky_q) begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase

    // A pixel arriving with sof_i is index 0 of the new frame
    if (start_frame) begin
      cnt_clr = 1'b1;
      if (valid_i) begin
        w_en_d   = 1'b1;
        w_data_d = pixel_i;
        w_addr_d = '0;
        row_d    = '0;
        col_d    = '0;
        cnt_inc  = 1'b1;
        if (TOTAL == 1) begin
          st_d   = FULL;
          done_d = 1'b1;
        end
      end
    end

    busy_d = (st_d != IDLE);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      row_q    <= row_d;
      col_q    <= col_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      sticky_q <= sticky_d;
    end
  end

  assign w_en_o       = w_en_q;
  assign w_addr_o     = w_addr_q;
  assign w_data_o     = w_data_q;
  assign row_o        = row_q;
  assign col_o        = col_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_vbuff_writer.sv
// Directed bench for vbuff_writer on a 4x2 frame.
module tb_vbuff_writer;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int ADDR_W = 3;

  logic              pclk = 1'b0;
  logic              rst = 1'b1;
  logic              capture_en_i = 1'b0;
  logic              sof_i = 1'b0;
  logic              valid_i = 1'b0;
  logic [3:0]        pixel_i = '0;
  logic [ADDR_W-1:0] w_addr_o;
  logic              w_en_o;
  logic [3:0]        w_data_o;
  logic [15:0]       row_o, col_o;
  logic              frame_done_o, frame_err_o, busy_o;

  int n_vec = 0;
  int n_err = 0;

  vbuff_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
    .pclk        (pclk),
    .rst         (rst),
    .capture_en_i(capture_en_i),
    .sof_i       (sof_i),
    .valid_i     (valid_i),
    .pixel_i     (pixel_i),
    .w_addr_o    (w_addr_o),
    .w_en_o      (w_en_o),
    .w_data_o    (w_data_o),
    .row_o       (row_o),
    .col_o       (col_o),
    .frame_done_o(frame_done_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the clock edge
  task automatic step(input logic s, input logic v, input logic [3:0] p);
    sof_i   = s;
    valid_i = v;
    pixel_i = p;
    @(posedge pclk);
    #1;
    sof_i   = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic en, input int addr, input int data,
                        input int row, input int col, input logic done, input logic err);
    chk({tag, ".w_en"}, 32'(w_en_o), 32'(en));
    if (en) begin
      chk({tag, ".addr"}, 32'(w_addr_o), 32'(addr));
      chk({tag, ".data"}, 32'(w_data_o), 32'(data));
      chk({tag, ".row"},  32'(row_o),    32'(row));
      chk({tag, ".col"},  32'(col_o),    32'(col));
    end
    chk({tag, ".done"}, 32'(frame_done_o), 32'(done));
    chk({tag, ".err"},  32'(frame_err_o),  32'(err));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".w_en"}, 32'(w_en_o), 0);
    chk({tag, ".addr"}, 32'(w_addr_o), 0);
    chk({tag, ".data"}, 32'(w_data_o), 0);
    chk({tag, ".row"},  32'(row_o), 0);
    chk({tag, ".col"},  32'(col_o), 0);
    chk({tag, ".done"}, 32'(frame_done_o), 0);
    chk({tag, ".err"},  32'(frame_err_o), 0);
    chk({tag, ".busy"}, 32'(busy_o), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Arm; pixels while ARMED without sof are dropped
    capture_en_i = 1'b1;
    step(0, 0, 0);
    chk("armed.busy", 32'(busy_o), 1);
    chk_wr("armed", 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4'd5);
    chk_wr("armed_px0", 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4'd6);
    chk_wr("armed_px1", 0, 0, 0, 0, 0, 0, 0);

    // Full frame: sof together with pixel 0, then 1..7
    step(1, 1, 4'd0);
    chk_wr("f1_px0", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 8; i++) begin
      step(0, 1, 4'(i));
      chk_wr($sformatf("f1_px%0d", i), 1, i, i, i / 4, i % 4, (i == 7), 0);
    end
    step(0, 0, 0);
    chk_wr("f1_after", 0, 0, 0, 0, 0, 0, 0);
    chk("f1_full.busy", 32'(busy_o), 1);

    // Long frame: three extra pixels in FULL, error pulses once
    step(0, 1, 4'd9);
    chk_wr("long0", 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 4'd10);
    chk_wr("long1", 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4'd11);
    chk_wr("long2", 0, 0, 0, 0, 0, 0, 0);

    // Short frame: sof, 5 pixels, sof, then a full 8 pixels
    step(1, 0, 0);
    chk_wr("short_sof", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 4'(8 + i));
      chk_wr($sformatf("short_px%0d", i), 1, i, 8 + i, i / 4, i % 4, 0, 0);
    end
    step(1, 0, 0);
    chk_wr("short_sof2", 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 4'(15 - i));
      chk_wr($sformatf("f2_px%0d", i), 1, i, 15 - i, i / 4, i % 4, (i == 7), 0);
    end

    // capture_en dropped mid-frame: frame completes, next sof goes idle
    step(1, 1, 4'd2);
    chk_wr("f3_px0", 1, 0, 2, 0, 0, 0, 0);
    for (int i = 1; i < 8; i++) begin
      if (i == 4) capture_en_i = 1'b0;
      step(0, 1, 4'(2 + i));
      chk_wr($sformatf("f3_px%0d", i), 1, i, 2 + i, i / 4, i % 4, (i == 7), 0);
    end
    step(0, 0, 0);
    chk("f3_full.busy", 32'(busy_o), 1);
    step(1, 1, 4'd7);
    chk_wr("f3_sof_idle", 0, 0, 0, 0, 0, 0, 0);
    chk("f3_idle.busy", 32'(busy_o), 0);

    // Reset mid-frame
    capture_en_i = 1'b1;
    step(0, 0, 0);
    chk("f4_armed.busy", 32'(busy_o), 1);
    step(1, 1, 4'd9);
    chk_wr("f4_px0", 1, 0, 9, 0, 0, 0, 0);
    step(0, 1, 4'd10);
    chk_wr("f4_px1", 1, 1, 10, 0, 1, 0, 0);
    step(0, 1, 4'd11);
    chk_wr("f4_px2", 1, 2, 11, 0, 2, 0, 0);
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    step(0, 1, 4'd12);
    chk_zero("rst_held");
    rst = 1'b0;
    step(0, 1, 4'd13);
    chk_wr("rearm", 0, 0, 0, 0, 0, 0, 0);
    chk("rearm.busy", 32'(busy_o), 1);
    step(0, 1, 4'd14);
    chk_wr("rearm_px", 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'd3);
    chk_wr("f5_px0", 1, 0, 3, 0, 0, 0, 0);
    step(0, 1, 4'd4);
    chk_wr("f5_px1", 1, 1, 4, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vbuff_writer.md
# vbuff_writer

Captures the demosaiced camera pixel stream into the video buffer so the display path can stream it back out on the same pixel clock. Arms on request, aligns to the camera start-of-frame strobe, and writes exactly WIDTH*HEIGHT pixels in raster order starting at address 0. It also detects short and long frames. It sits between the OV7670 capture/demosaic path and the vbuff write port.

## Interface
- WIDTH, 640: pixels per line.
- HEIGHT, 480: lines per frame.
- ADDR_W, $clog2(WIDTH*HEIGHT): vbuff address width.
- pclk  input  1  pixel clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- capture_en_i  input  1  level; 1 = keep capturing frames, 0 = stop after the current frame.
- sof_i  input  1  one-cycle start-of-frame strobe from capture.
- valid_i  input  1  pixel_i holds a pixel this cycle.
- pixel_i  input  4  pixel value.
- w_addr_o  output  ADDR_W  vbuff write address.
- w_en_o  output  1  vbuff write enable.
- w_data_o  output  4  vbuff write data.
- row_o, col_o  output  16 each  raster position of the pixel being written.
- frame_done_o  output  1  pulse: last pixel of a complete frame written.
- frame_err_o  output  1  pulse: short or long frame detected.
- busy_o  output  1  1 in ARMED, WRITE or FULL.

## Operation
- States:
  - IDLE
  - ARMED: waiting for the first sof_i.
  - WRITE: accepting pixels.
  - FULL: frame complete, discarding pixels until the next sof_i.
- Transitions:
  - IDLE -> ARMED when capture_en_i=1.
  - ARMED -> WRITE on sof_i; pixel index cleared to 0. valid_i in ARMED without sof_i is ignored.
  - WRITE, valid_i=1: write pixel at the current index, then increment the index.
  - WRITE, write of index WIDTH*HEIGHT-1: go to FULL and pulse frame_done_o.
  - WRITE, sof_i before the frame completes (short frame): pulse frame_err_o, clear index to 0. Stay in WRITE if capture_en_i=1, else go to IDLE.
  - FULL, sof_i: go to WRITE with index 0 if capture_en_i=1, else go to IDLE.
  - FULL, valid_i=1 (long frame): pixel is discarded (no w_en_o). frame_err_o pulses on the first such pixel only; a sticky flag suppresses further pulses and is cleared by sof_i.
- sof_i together with valid_i in the same cycle: the pixel is index 0 of the new frame and is written.
- Index counters:
  - col wraps WIDTH-1 -> 0 and increments row.
  - row counts 0..HEIGHT-1.
  - addr = row*WIDTH+col, held as a separate incrementing counter; no multiplier.
- capture_en_i deasserted mid-frame does not abort; the frame completes and the block returns to IDLE at the next sof_i.

## Timing
- All outputs are registered. Reset value of every output is 0; state IDLE; counters 0.
- Latency: valid_i/pixel_i at cycle N -> w_en_o, w_data_o, w_addr_o, row_o, col_o at cycle N+1.
- w_en_o is high only in the cycle after an accepted pixel; address and data are stable in the same cycle.
- frame_done_o is high in the same cycle as the w_en_o for index WIDTH*HEIGHT-1.
- frame_err_o is registered and one cycle wide; it fires in the cycle after the offending sof_i or valid_i.
- Back-to-back pixels every cycle are supported with no bubbles.
- rst asserted mid-frame: immediate return to IDLE. Nothing further is written; a partial frame stays in memory.

## Structure
- Shared package vbuff_pkg holds:
  - the typedef enum for the writer state {IDLE, ARMED, WRITE, FULL};
  - default WIDTH/HEIGHT constants, shared with the buffer reader.
- One sub-module, raster_counter (parameters WIDTH, HEIGHT), holds col/row/addr with clear, increment and last-pixel flag. It is reusable by the reader.
- The FSM and output registers live in vbuff_writer.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2.
- Reset, then capture_en_i=1 and sof_i, then 8 consecutive valid pixels 0..7 -> 8 writes at addresses 0..7 with data 0..7; row/col go (0,0)..(1,3); frame_done_o high with addr 7; state FULL.
- Valid pixels before the first sof_i while ARMED -> no w_en_o; the first write after sof_i is at address 0.
- Short frame: sof_i, 5 pixels, sof_i, 8 pixels -> frame_err_o pulses once after the second sof_i. The next writes restart at address 0 and frame_done_o fires on the 8th.
- Long frame: after a full frame, 3 extra valid pixels before sof_i -> no writes; frame_err_o pulses exactly once.
- capture_en_i dropped after pixel 3 -> pixels 4..7 are still written and frame_done_o fires; the next sof_i returns the block to IDLE with busy_o=0.
- rst pulsed after pixel 2 -> all outputs 0 next cycle; no further writes until re-armed and a new sof_i.
